alu_seq16: RTL and testbench
============================

ALU_SEQ16 -- requirements
Module: alu_seq16

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-high; ports are CLK and RESET.
REQ-002 CLK  in  1  rising-edge clock for all state.
REQ-003 RESET  in  1  asynchronous, active-high; forces reset state immediately.
REQ-004 START  in  1  request pulse; sampled only in IDLE.
REQ-005 CMD  in  2  0=ADD16, 1=XOR16, 2=SHL16, 3=reserved (NOP).
REQ-006 OPA  in  16  operand A; OPB  in  16  operand B; SHAMT  in  4  shift count for SHL16.
REQ-007 ALU_OP  out  4  opcode to the shared 8-bit ALU; ALU_A, ALU_B  out  8  ALU data inputs; ALU_SC_IN  out  1  ALU carry/shift-in.
REQ-008 ALU_OUT  in  8  ALU result; ALU_SC_OUT  in  1  ALU carry/shift-out.
REQ-009 RES  out  16  registered result; CARRY  out  1  registered carry out; BUSY  out  1  sequence in progress; DONE  out  1  one-cycle completion pulse.

Function
REQ-010 FSM states SHALL be IDLE, LO, HI, FIN; BUSY=1 in LO, HI and FIN, 0 in IDLE.
REQ-011 In IDLE with START=1 at edge k: latch OPA, OPB, CMD and SHAMT into internal registers; CMD/operand changes after k have no effect.
REQ-012 Transitions from IDLE on START: CMD 0/1 -> LO; CMD 2 with SHAMT>0 -> LO; CMD 2 with SHAMT=0 -> FIN; CMD 3 -> FIN.
REQ-013 START in LO, HI or FIN SHALL be ignored (no queueing).
REQ-014 ADD16: LO drives kADDL, ALU_A=A[7:0], ALU_B=B[7:0], ALU_SC_IN=0, captures ALU_OUT->RES[7:0] and ALU_SC_OUT->carry reg; HI drives kADDL on A[15:8], B[15:8] with ALU_SC_IN=carry reg, captures RES[15:8] and CARRY.
REQ-015 XOR16: same LO/HI byte order with kXOR; CARRY=0.
REQ-016 SHL16: working register W loaded with A; LO drives kSLG with ALU_B=W[7:0], captures W[7:0] and shift-out bit; HI drives kSLO with ALU_B=W[15:8], ALU_SC_IN=shift-out bit, captures W[15:8]; count decrements in HI.
REQ-017 SHL16 HI SHALL return to LO while remaining count>0, else go to FIN with RES=W; CARRY=0 for SHL16.
REQ-018 SHAMT=0 SHL16: RES=A, CARRY=0; NOP: RES=0, CARRY=0.
REQ-019 FIN SHALL assert DONE for exactly one cycle and return to IDLE unconditionally.
REQ-020 Latency from START edge k to DONE high: ADD16/XOR16 cycle k+3; SHL16 cycle k+2n+1 (n=SHAMT); SHAMT=0 or NOP cycle k+1.
REQ-021 RES and CARRY SHALL be held stable from FIN until the next accepted START's first capture.
REQ-022 Outside LO/HI the block SHALL drive ALU_OP=kADDL, ALU_A=0, ALU_B=0, ALU_SC_IN=0.
REQ-023 ALU path is combinational; results SHALL be captured at the end of the same cycle the opcode is driven.

Reset
REQ-024 RESET SHALL force state=IDLE, RES=0, CARRY=0, BUSY=0, DONE=0, all internal registers 0, asynchronously.
REQ-025 RESET mid-sequence SHALL abort with no DONE pulse; the first START after RESET deasserts starts a fresh sequence.

Structure
REQ-026 The CMD enum and FSM state enum SHALL be defined in the shared definitionsABC package; ALU opcode mnemonics (kADDL, kXOR, kSLG, kSLO) SHALL be reused from that package.
REQ-027 No sub-module; the 8-bit ALU is instantiated by the enclosing datapath and wired to ALU_* ports.

Verification
REQ-028 ADD16 A=0x12FF, B=0x0001, START at k -> RES=0x1300, CARRY=0, DONE high at k+3 only.
REQ-029 ADD16 A=0xFFFF, B=0x0001 -> RES=0x0000, CARRY=1; XOR16 A=0xA5A5, B=0x0FF0 -> RES=0xAA55, CARRY=0.
REQ-030 SHL16 A=0x0081, SHAMT=1 -> RES=0x0102 at k+3; SHAMT=9 -> RES=0x0200, DONE at k+19; SHAMT=0 -> RES=0x0081, DONE at k+1.
REQ-031 START pulsed again during HI of ADD16 -> ignored, single DONE, result of first operation only.
REQ-032 RESET asserted mid-clock during HI of SHL16 -> BUSY, DONE, RES, CARRY 0 before next edge; no DONE pulse; subsequent ADD16 correct.

Source files
------------

// File: rtl/alu_seq16_pkg.sv
// Shared definitions for the 16-bit sequencer: command and state encodings
// plus the opcode mnemonics understood by the shared 8-bit ALU.
package definitionsABC;

   localparam int WORD_W   = 16;
   localparam int BYTE_W   = 8;
   localparam int SHAMT_W  = 4;
   localparam int ALU_OP_W = 4;

   typedef enum logic [1:0] {
      CMD_ADD16 = 2'd0,
      CMD_XOR16 = 2'd1,
      CMD_SHL16 = 2'd2,
      CMD_NOP   = 2'd3
   } cmd_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      FIN  = 2'd3
   } state_e;

   localparam logic [ALU_OP_W-1:0] kADDL = 4'h0;
   localparam logic [ALU_OP_W-1:0] kXOR  = 4'h1;
   localparam logic [ALU_OP_W-1:0] kSLG  = 4'h2;
   localparam logic [ALU_OP_W-1:0] kSLO  = 4'h3;

endpackage

// File: rtl/alu_seq16.sv
// Sequences 16-bit ADD/XOR/SHL operations as low-byte/high-byte passes through
// an external combinational 8-bit ALU; one shift position per LO/HI pair.
module alu_seq16
   import definitionsABC::*;
(
   input  logic                CLK,
   input  logic                RESET,
   input  logic                START,
   input  logic [1:0]          CMD,
   input  logic [WORD_W-1:0]   OPA,
   input  logic [WORD_W-1:0]   OPB,
   input  logic [SHAMT_W-1:0]  SHAMT,
   output logic [ALU_OP_W-1:0] ALU_OP,
   output logic [BYTE_W-1:0]   ALU_A,
   output logic [BYTE_W-1:0]   ALU_B,
   output logic                ALU_SC_IN,
   input  logic [BYTE_W-1:0]   ALU_OUT,
   input  logic                ALU_SC_OUT,
   output logic [WORD_W-1:0]   RES,
   output logic                CARRY,
   output logic                BUSY,
   output logic                DONE
);

   state_e               state, state_nxt;
   cmd_e                 cmd_q;
   logic [WORD_W-1:0]    a_q, b_q, w_q;
   logic [SHAMT_W-1:0]   cnt_q;
   logic                 c_q;   // byte carry for ADD16, shift-out bit for SHL16

   always_comb begin
      state_nxt = state;
      ALU_OP    = kADDL;
      ALU_A     = '0;
      ALU_B     = '0;
      ALU_SC_IN = 1'b0;
      case (state)
         IDLE: begin
            if (START) begin
               case (cmd_e'(CMD))
                  CMD_ADD16, CMD_XOR16: state_nxt = LO;
                  CMD_SHL16:            state_nxt = (SHAMT != '0) ? LO : FIN;
                  default:              state_nxt = FIN;
               endcase
            end
         end
         LO: begin
            state_nxt = HI;
            case (cmd_q)
               CMD_ADD16: begin
                  ALU_OP = kADDL;
                  ALU_A  = a_q[7:0];
                  ALU_B  = b_q[7:0];
               end
               CMD_XOR16: begin
                  ALU_OP = kXOR;
                  ALU_A  = a_q[7:0];
                  ALU_B  = b_q[7:0];
               end
               CMD_SHL16: begin
                  ALU_OP = kSLG;
                  ALU_B  = w_q[7:0];
               end
               default: ;
            endcase
         end
         HI: begin
            state_nxt = (cmd_q == CMD_SHL16 && cnt_q > 4'd1) ? LO : FIN;
            case (cmd_q)
               CMD_ADD16: begin
                  ALU_OP    = kADDL;
                  ALU_A     = a_q[15:8];
                  ALU_B     = b_q[15:8];
                  ALU_SC_IN = c_q;
               end
               CMD_XOR16: begin
                  ALU_OP = kXOR;
                  ALU_A  = a_q[15:8];
                  ALU_B  = b_q[15:8];
               end
               CMD_SHL16: begin
                  ALU_OP    = kSLO;
                  ALU_B     = w_q[15:8];
                  ALU_SC_IN = c_q;
               end
               default: ;
            endcase
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign BUSY = (state != IDLE);
   assign DONE = (state == FIN);

   // Captures happen at the end of the cycle whose opcode is on ALU_OP.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
         cmd_q <= CMD_ADD16;
         a_q   <= '0;
         b_q   <= '0;
         w_q   <= '0;
         cnt_q <= '0;
         c_q   <= 1'b0;
         RES   <= '0;
         CARRY <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (START) begin
                  a_q   <= OPA;
                  b_q   <= OPB;
                  w_q   <= OPA;
                  cmd_q <= cmd_e'(CMD);
                  cnt_q <= SHAMT;
                  c_q   <= 1'b0;
                  if (cmd_e'(CMD) == CMD_SHL16 && SHAMT == '0) begin
                     RES   <= OPA;
                     CARRY <= 1'b0;
                  end else if (cmd_e'(CMD) == CMD_NOP) begin
                     RES   <= '0;
                     CARRY <= 1'b0;
                  end
               end
            end
            LO: begin
               c_q <= ALU_SC_OUT;
               if (cmd_q == CMD_SHL16) w_q[7:0] <= ALU_OUT;
               else                    RES[7:0] <= ALU_OUT;
            end
            HI: begin
               if (cmd_q == CMD_SHL16) begin
                  w_q[15:8] <= ALU_OUT;
                  cnt_q     <= cnt_q - 4'd1;
                  if (cnt_q == 4'd1) begin
                     RES   <= {ALU_OUT, w_q[7:0]};
                     CARRY <= 1'b0;
                  end
               end else begin
                  RES[15:8] <= ALU_OUT;
                  CARRY     <= (cmd_q == CMD_ADD16) ? ALU_SC_OUT : 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq16.sv
// Bench for alu_seq16: an 8-bit ALU model closes the loop, expectations from a
// 16-bit arithmetic reference are queued on START and popped on DONE.
module tb_alu_seq16;
   import definitionsABC::*;

   logic        CLK = 1'b0;
   logic        RESET, START;
   logic [1:0]  CMD;
   logic [15:0] OPA, OPB;
   logic [3:0]  SHAMT;
   logic [3:0]  ALU_OP;
   logic [7:0]  ALU_A, ALU_B, ALU_OUT;
   logic        ALU_SC_IN, ALU_SC_OUT;
   logic [15:0] RES;
   logic        CARRY, BUSY, DONE;

   typedef struct {
      logic [15:0] res;
      logic        carry;
      int          done_cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   alu_seq16 dut (
      .CLK(CLK), .RESET(RESET), .START(START), .CMD(CMD),
      .OPA(OPA), .OPB(OPB), .SHAMT(SHAMT),
      .ALU_OP(ALU_OP), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_SC_IN(ALU_SC_IN),
      .ALU_OUT(ALU_OUT), .ALU_SC_OUT(ALU_SC_OUT),
      .RES(RES), .CARRY(CARRY), .BUSY(BUSY), .DONE(DONE)
   );

   // Shared 8-bit ALU seen by the sequencer
   always_comb begin
      ALU_OUT    = '0;
      ALU_SC_OUT = 1'b0;
      case (ALU_OP)
         kADDL: {ALU_SC_OUT, ALU_OUT} = {1'b0, ALU_A} + {1'b0, ALU_B} + {8'd0, ALU_SC_IN};
         kXOR:  ALU_OUT = ALU_A ^ ALU_B;
         kSLG: begin
            ALU_OUT    = {ALU_B[6:0], 1'b0};
            ALU_SC_OUT = ALU_B[7];
         end
         kSLO: begin
            ALU_OUT    = {ALU_B[6:0], ALU_SC_IN};
            ALU_SC_OUT = ALU_B[7];
         end
         default: ;
      endcase
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
      end
   endtask

   function automatic void ref_op(input logic [1:0] c, input logic [15:0] a, input logic [15:0] b,
                                  input logic [3:0] n, output logic [15:0] r, output logic cy,
                                  output int lat);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      case (c)
         2'd0: begin r = sum[15:0]; cy = sum[16]; lat = 3; end
         2'd1: begin r = a ^ b; cy = 1'b0; lat = 3; end
         2'd2: begin r = a << n; cy = 1'b0; lat = (n == 4'd0) ? 1 : 2 * int'(n) + 1; end
         default: begin r = '0; cy = 1'b0; lat = 1; end
      endcase
   endfunction

   // Monitor: every DONE must match the oldest outstanding expectation
   always @(negedge CLK) begin
      exp_t e;
      if (DONE) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done_spurious actual=1 required=0 cyc=%0d", cyc);
         end else begin
            e = q.pop_front();
            check("res", {16'd0, RES}, {16'd0, e.res});
            check("carry", {31'd0, CARRY}, {31'd0, e.carry});
            check("done_cycle", cyc, e.done_cyc);
            check("busy_at_done", {31'd0, BUSY}, 32'd1);
         end
      end
      if (!BUSY)
         check("alu_idle_drive", {15'd0, ALU_OP, ALU_A, ALU_B, ALU_SC_IN}, {15'd0, kADDL, 17'd0});
   end

   task automatic wait_idle();
      for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge CLK);
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL done_timeout actual=pending required=done cyc=%0d", cyc);
         q.delete();
      end
   endtask

   task automatic issue(input logic [1:0] c, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] n, input bit poke);
      logic [15:0] r;
      logic        cy;
      int          lat;
      exp_t        e;
      @(negedge CLK);
      check("busy_before_start", {31'd0, BUSY}, 32'd0);
      ref_op(c, a, b, n, r, cy, lat);
      e.res = r;
      e.carry = cy;
      e.done_cyc = cyc + lat;
      q.push_back(e);
      START = 1'b1; CMD = c; OPA = a; OPB = b; SHAMT = n;
      @(negedge CLK);
      START = 1'b0;
      CMD = 2'($urandom); OPA = 16'($urandom); OPB = 16'($urandom); SHAMT = 4'($urandom);
      if (poke && lat > 1) begin
         @(negedge CLK);
         START = 1'b1;
         CMD = 2'($urandom);
         @(negedge CLK);
         START = 1'b0;
      end
      wait_idle();
   endtask

   initial begin
      RESET = 1'b1; START = 1'b0; CMD = '0; OPA = '0; OPB = '0; SHAMT = '0;
      repeat (2) @(negedge CLK);
      check("reset_res", {16'd0, RES}, 32'd0);
      check("reset_carry", {31'd0, CARRY}, 32'd0);
      check("reset_busy", {31'd0, BUSY}, 32'd0);
      check("reset_done", {31'd0, DONE}, 32'd0);
      RESET = 1'b0;

      issue(2'd0, 16'h12FF, 16'h0001, 4'd0, 1'b0);
      check("add_12ff_const", {16'd0, RES}, 32'h1300);
      issue(2'd0, 16'hFFFF, 16'h0001, 4'd0, 1'b0);
      check("add_ffff_const", {15'd0, CARRY, RES}, 32'h1_0000);
      issue(2'd1, 16'hA5A5, 16'h0FF0, 4'd0, 1'b0);
      check("xor_const", {15'd0, CARRY, RES}, 32'h0_AA55);
      issue(2'd2, 16'h0081, 16'h0000, 4'd1, 1'b0);
      check("shl1_const", {16'd0, RES}, 32'h0102);
      issue(2'd2, 16'h0081, 16'h0000, 4'd9, 1'b0);
      check("shl9_const", {16'd0, RES}, 32'h0200);
      issue(2'd2, 16'h0081, 16'h0000, 4'd0, 1'b0);
      check("shl0_const", {16'd0, RES}, 32'h0081);
      issue(2'd3, 16'h1234, 16'h5678, 4'd7, 1'b0);
      check("nop_const", {15'd0, CARRY, RES}, 32'h0);
      issue(2'd0, 16'h00FF, 16'h0F01, 4'd0, 1'b1);
      check("add_poke_const", {16'd0, RES}, 32'h1000);

      // Reset asserted mid-clock during HI of a shift
      @(negedge CLK);
      START = 1'b1; CMD = 2'd2; OPA = 16'h0081; OPB = 16'h0; SHAMT = 4'd5;
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      #2 RESET = 1'b1;
      #1;
      check("midreset_res", {16'd0, RES}, 32'd0);
      check("midreset_carry", {31'd0, CARRY}, 32'd0);
      check("midreset_busy", {31'd0, BUSY}, 32'd0);
      check("midreset_done", {31'd0, DONE}, 32'd0);
      @(negedge CLK);
      RESET = 1'b0;
      repeat (12) @(negedge CLK);
      issue(2'd0, 16'h7FFF, 16'h8001, 4'd0, 1'b0);
      check("post_reset_add", {15'd0, CARRY, RES}, 32'h1_0000);

      for (int i = 0; i < 60; i++)
         issue(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
               4'($urandom), ($urandom_range(0, 3) == 0));

      repeat (3) @(negedge CLK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
